// File: rtl/iommu_pkg.sv
// Shared types for the IOMMU context caches: the widest tag any cache
// instance may need, and the decoded flush granularity.
package iommu_pkg;

  localparam int DID_MAX_W = 24;
  localparam int PID_MAX_W = 20;

  // Narrower instances zero-fill the unused upper bits, so a full struct
  // compare stays correct for every width.
  typedef struct packed {
    logic [DID_MAX_W-1:0] did;
    logic [PID_MAX_W-1:0] pid;
  } ctx_cache_tag_t;

  typedef enum logic [1:0] {
    FL_ALL,
    FL_DID,
    FL_DID_PID
  } flush_mode_e;

  function automatic flush_mode_e decode_flush(input logic dv, input logic pv);
    if (!dv) return FL_ALL;
    if (pv) return FL_DID_PID;
    return FL_DID;
  endfunction

endpackage

// File: rtl/iommu_plru_tree.sv
// Tree pseudo-LRU for a fully associative structure. Each node bit points at
// the less recently used half (0 = lower half). Several touches in one cycle
// are applied in port order, so the highest-numbered touch wins where paths
// overlap.
module iommu_plru_tree #(
  parameter int ENTRIES = 4,
  parameter int NTOUCH  = 2,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NTOUCH-1:0]  touch_i,
  input  logic [IDX_W-1:0]   touch_idx_i [NTOUCH],
  output logic [ENTRIES-1:0] victim_oh_o
);

  logic [ENTRIES-2:0] tree_q;
  logic [ENTRIES-2:0] tree_d;

  // Walk each touched entry's root-to-leaf path and point every node away from it.
  always_comb begin
    int node;
    node   = 0;
    tree_d = tree_q;
    for (int t = 0; t < NTOUCH; t++) begin
      if (touch_i[t]) begin
        node = 0;
        for (int l = 0; l < IDX_W; l++) begin
          tree_d[node] = ~touch_idx_i[t][IDX_W-1-l];
          node = 2 * node + 1 + (touch_idx_i[t][IDX_W-1-l] ? 1 : 0);
        end
      end
    end
  end

  // Follow the node bits from the root down to the least recently used leaf.
  always_comb begin
    int vnode;
    vnode       = 0;
    victim_oh_o = '0;
    for (int l = 0; l < IDX_W; l++) begin
      vnode = 2 * vnode + 1 + (tree_q[vnode] ? 1 : 0);
    end
    victim_oh_o[vnode-(ENTRIES-1)] = 1'b1;
  end

  // Tree state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) tree_q <= '0;
    else       tree_q <= tree_d;
  end

endmodule

// File: rtl/iommu_ctx_cache.sv
// Fully associative context cache (DDTC with PID_EN=0, PDTC with PID_EN=1).
// Lookups see the state before the accepting edge and answer one cycle
// later; flushes beat updates; hit/miss counters saturate.
module iommu_ctx_cache
  import iommu_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int DID_W   = 24,
  parameter int PID_EN  = 0,
  parameter int PID_W   = 20,
  parameter int DATA_W  = 512,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              flush_dv_i,
  input  logic              flush_pv_i,
  input  logic [DID_W-1:0]  flush_did_i,
  input  logic [PID_W-1:0]  flush_pid_i,
  input  logic              up_valid_i,
  input  logic [DID_W-1:0]  up_did_i,
  input  logic [PID_W-1:0]  up_pid_i,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic              lu_valid_i,
  output logic              lu_ready_o,
  input  logic [DID_W-1:0]  lu_did_i,
  input  logic [PID_W-1:0]  lu_pid_i,
  output logic              lu_rsp_valid_o,
  output logic              lu_hit_o,
  output logic [DATA_W-1:0] lu_data_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  ctx_cache_tag_t     tag_q  [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic               rsp_valid_q, rsp_hit_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

  ctx_cache_tag_t     lu_tag, up_tag, fl_tag;
  flush_mode_e        fl_mode;
  logic [ENTRIES-1:0] lu_match, up_match, fl_match, victim_oh;
  logic [IDX_W-1:0]   lu_idx, uh_idx, free_idx, victim_idx, up_idx;
  logic               lu_hit, up_hit, have_free, lu_accept, up_write;
  logic [1:0]         touch;
  logic [IDX_W-1:0]   touch_idx [2];

  // With PID_EN=0 the pid field stays zero, so it never distinguishes entries.
  function automatic ctx_cache_tag_t make_tag(input logic [DID_W-1:0] did,
                                              input logic [PID_W-1:0] pid);
    ctx_cache_tag_t t;
    t = '0;
    t.did[DID_W-1:0] = did;
    if (PID_EN != 0) t.pid[PID_W-1:0] = pid;
    return t;
  endfunction

  assign lu_ready_o = !flush_i && !rst_i;

  // Compare every stored tag against the lookup, update and flush keys.
  always_comb begin
    lu_tag  = make_tag(lu_did_i, lu_pid_i);
    up_tag  = make_tag(up_did_i, up_pid_i);
    fl_tag  = make_tag(flush_did_i, flush_pid_i);
    fl_mode = decode_flush(flush_dv_i, flush_pv_i);
    for (int i = 0; i < ENTRIES; i++) begin
      lu_match[i] = valid_q[i] && (tag_q[i] == lu_tag);
      up_match[i] = valid_q[i] && (tag_q[i] == up_tag);
      case (fl_mode)
        FL_ALL:  fl_match[i] = 1'b1;
        FL_DID:  fl_match[i] = (tag_q[i].did == fl_tag.did);
        default: fl_match[i] = (tag_q[i] == fl_tag);
      endcase
    end
  end

  // Encode hit and free indices (lowest index wins) and choose the write slot.
  always_comb begin
    lu_idx     = '0;
    uh_idx     = '0;
    free_idx   = '0;
    victim_idx = '0;
    have_free  = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lu_match[i])  lu_idx = IDX_W'(i);
      if (up_match[i])  uh_idx = IDX_W'(i);
      if (victim_oh[i]) victim_idx = IDX_W'(i);
      if (!valid_q[i]) begin
        free_idx  = IDX_W'(i);
        have_free = 1'b1;
      end
    end
    lu_hit       = |lu_match;
    up_hit       = |up_match;
    up_idx       = up_hit ? uh_idx : (have_free ? free_idx : victim_idx);
    lu_accept    = lu_valid_i && lu_ready_o;
    up_write     = up_valid_i && !flush_i;
    touch        = {up_write, lu_accept && lu_hit};
    touch_idx[0] = lu_idx;
    touch_idx[1] = up_idx;
  end

  iommu_plru_tree #(
    .ENTRIES (ENTRIES),
    .NTOUCH  (2)
  ) u_plru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .touch_i     (touch),
    .touch_idx_i (touch_idx),
    .victim_oh_o (victim_oh)
  );

  // Valid bits, the registered response and the saturating counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      rsp_valid_q <= lu_accept;
      rsp_hit_q   <= lu_accept && lu_hit;
      rsp_data_q  <= (lu_accept && lu_hit) ? data_q[lu_idx] : '0;
      if (lu_accept && lu_hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (lu_accept && !lu_hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (flush_i)       valid_q         <= valid_q & ~fl_match;
      else if (up_write) valid_q[up_idx] <= 1'b1;
    end
  end

  // Tag and payload storage needs no reset; it is only read behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (up_write) begin
      tag_q[up_idx]  <= up_tag;
      data_q[up_idx] <= up_data_i;
    end
  end

  assign lu_rsp_valid_o = rsp_valid_q;
  assign lu_hit_o       = rsp_hit_q;
  assign lu_data_o      = rsp_data_q;
  assign hit_cnt_o      = hit_cnt_q;
  assign miss_cnt_o     = miss_cnt_q;

  a_lu_unique: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(lu_match));
  a_up_unique: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(up_match));
  a_victim_oh: assert property (@(posedge clk_i) disable iff (rst_i) $onehot(victim_oh));
  a_flush_pv:  assert property (@(posedge clk_i) disable iff (rst_i)
                                !(flush_i && flush_pv_i && !flush_dv_i));

endmodule

// File: tb/tb_iommu_ctx_cache.sv
// Bench for iommu_ctx_cache: one DDTC-style instance (PID_EN=0, 2-bit
// counters) and one PDTC-style instance (PID_EN=1, 16-bit counters) share
// stimulus and are checked against a recency-timestamp reference model.
module tb_iommu_ctx_cache;

  localparam int ENTRIES = 4;
  localparam int DID_W   = 8;
  localparam int PID_W   = 4;
  localparam int DATA_W  = 32;
  localparam int CW0     = 2;
  localparam int CW1     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, flush_dv, flush_pv, up_valid, lu_valid;
  logic [DID_W-1:0]  flush_did, up_did, lu_did;
  logic [PID_W-1:0]  flush_pid, up_pid, lu_pid;
  logic [DATA_W-1:0] up_data;

  logic              ready     [2];
  logic              rsp_valid [2];
  logic              rsp_hit   [2];
  logic [DATA_W-1:0] rsp_data  [2];
  logic [CW0-1:0]    hc0, mc0;
  logic [CW1-1:0]    hc1, mc1;
  logic [15:0]       hit_cnt   [2];
  logic [15:0]       miss_cnt  [2];

  assign hit_cnt[0]  = {14'b0, hc0};
  assign miss_cnt[0] = {14'b0, mc0};
  assign hit_cnt[1]  = hc1;
  assign miss_cnt[1] = mc1;

  iommu_ctx_cache #(
    .ENTRIES(ENTRIES), .DID_W(DID_W), .PID_EN(0), .PID_W(PID_W), .DATA_W(DATA_W), .CNT_W(CW0)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_dv_i(flush_dv), .flush_pv_i(flush_pv),
    .flush_did_i(flush_did), .flush_pid_i(flush_pid), .up_valid_i(up_valid), .up_did_i(up_did),
    .up_pid_i(up_pid), .up_data_i(up_data), .lu_valid_i(lu_valid), .lu_ready_o(ready[0]),
    .lu_did_i(lu_did), .lu_pid_i(lu_pid), .lu_rsp_valid_o(rsp_valid[0]), .lu_hit_o(rsp_hit[0]),
    .lu_data_o(rsp_data[0]), .hit_cnt_o(hc0), .miss_cnt_o(mc0)
  );

  iommu_ctx_cache #(
    .ENTRIES(ENTRIES), .DID_W(DID_W), .PID_EN(1), .PID_W(PID_W), .DATA_W(DATA_W), .CNT_W(CW1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_dv_i(flush_dv), .flush_pv_i(flush_pv),
    .flush_did_i(flush_did), .flush_pid_i(flush_pid), .up_valid_i(up_valid), .up_did_i(up_did),
    .up_pid_i(up_pid), .up_data_i(up_data), .lu_valid_i(lu_valid), .lu_ready_o(ready[1]),
    .lu_did_i(lu_did), .lu_pid_i(lu_pid), .lu_rsp_valid_o(rsp_valid[1]), .lu_hit_o(rsp_hit[1]),
    .lu_data_o(rsp_data[1]), .hit_cnt_o(hc1), .miss_cnt_o(mc1)
  );

  // Reference model: per-instance entry table plus last-use timestamps.
  bit                m_valid [2][ENTRIES];
  logic [DID_W-1:0]  m_did   [2][ENTRIES];
  logic [PID_W-1:0]  m_pid   [2][ENTRIES];
  logic [DATA_W-1:0] m_data  [2][ENTRIES];
  longint            m_ts    [2][ENTRIES];
  int                m_hits  [2];
  int                m_miss  [2];
  bit                exp_valid [2];
  bit                exp_hit   [2];
  logic [DATA_W-1:0] exp_data  [2];
  longint            now_t = 1;
  int                n_vec = 0;
  int                n_err = 0;

  function automatic int cnt_max(int m);
    return (m == 0) ? 3 : 65535;
  endfunction

  function automatic int m_find(int m, logic [DID_W-1:0] d, logic [PID_W-1:0] p);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[m][i] && m_did[m][i] == d && (m == 0 || m_pid[m][i] == p)) return i;
    return -1;
  endfunction

  function automatic longint max_ts(int m, int lo, int n);
    longint r = 0;
    for (int i = lo; i < lo + n; i++) if (m_ts[m][i] > r) r = m_ts[m][i];
    return r;
  endfunction

  // Tree PLRU equals: at each split go to the half whose latest use is older.
  function automatic int m_victim(int m);
    int lo = 0;
    int span = ENTRIES;
    while (span > 1) begin
      span = span / 2;
      if (max_ts(m, lo + span, span) < max_ts(m, lo, span)) lo = lo + span;
    end
    return lo;
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUTs.
  task automatic step();
    for (int m = 0; m < 2; m++) begin
      int li, ui, vic, wi;
      if (rst) begin
        for (int i = 0; i < ENTRIES; i++) begin
          m_valid[m][i] = 0;
          m_ts[m][i] = 0;
        end
        m_hits[m] = 0; m_miss[m] = 0;
        exp_valid[m] = 0; exp_hit[m] = 0; exp_data[m] = '0;
      end else begin
        li  = m_find(m, lu_did, lu_pid);
        ui  = m_find(m, up_did, up_pid);
        vic = m_victim(m);
        exp_valid[m] = lu_valid && !flush;
        exp_hit[m]   = exp_valid[m] && (li >= 0);
        exp_data[m]  = '0;
        if (exp_hit[m]) begin
          exp_data[m] = m_data[m][li];
          m_ts[m][li] = 2 * now_t;
          if (m_hits[m] < cnt_max(m)) m_hits[m]++;
        end else if (exp_valid[m]) begin
          if (m_miss[m] < cnt_max(m)) m_miss[m]++;
        end
        if (flush) begin
          for (int i = 0; i < ENTRIES; i++)
            if (!flush_dv || (m_did[m][i] == flush_did &&
                              (!flush_pv || m == 0 || m_pid[m][i] == flush_pid)))
              m_valid[m][i] = 0;
        end else if (up_valid) begin
          wi = ui;
          for (int i = 0; i < ENTRIES; i++) if (wi < 0 && !m_valid[m][i]) wi = i;
          if (wi < 0) wi = vic;
          m_valid[m][wi] = 1;
          m_did[m][wi]   = up_did;
          m_pid[m][wi]   = up_pid;
          m_data[m][wi]  = up_data;
          m_ts[m][wi]    = 2 * now_t + 1;
        end
      end
    end
    now_t++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; flush = 0; flush_dv = 0; flush_pv = 0; flush_did = '0; flush_pid = '0;
    up_valid = 0; up_did = '0; up_pid = '0; up_data = '0;
    lu_valid = 0; lu_did = '0; lu_pid = '0;
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1; step(); step(); rst = 0;
  endtask

  task automatic do_update(input logic [DID_W-1:0] d, input logic [PID_W-1:0] p,
                           input logic [DATA_W-1:0] v);
    clear_inputs(); up_valid = 1; up_did = d; up_pid = p; up_data = v; step(); clear_inputs();
  endtask

  task automatic do_lookup(input logic [DID_W-1:0] d, input logic [PID_W-1:0] p);
    clear_inputs(); lu_valid = 1; lu_did = d; lu_pid = p; step(); clear_inputs();
  endtask

  task automatic do_flush(input logic dv, input logic pv, input logic [DID_W-1:0] d,
                          input logic [PID_W-1:0] p);
    clear_inputs(); flush = 1; flush_dv = dv; flush_pv = pv; flush_did = d; flush_pid = p;
    step(); clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs(); rst = 1; lu_valid = 1; lu_did = 8'h12;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (ready[m] !== 1'b0) begin
        n_err++; $display("[TB] FAIL reset_ready dut%0d: got %b want 0", m, ready[m]);
      end
    end
    step(); step();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_valid[m] !== 1'b0 || hit_cnt[m] !== 16'd0 || miss_cnt[m] !== 16'd0) begin
        n_err++;
        $display("[TB] FAIL reset_state dut%0d: got v=%b h=%0d m=%0d want 0/0/0",
                 m, rsp_valid[m], hit_cnt[m], miss_cnt[m]);
      end
    end
    clear_inputs();
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (ready[m] !== 1'b1) begin
        n_err++; $display("[TB] FAIL post_reset_ready dut%0d: got %b want 1", m, ready[m]);
      end
    end
  endtask

  task automatic test_first_lookup();
    do_lookup(8'h12, 4'h0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_valid[m] !== 1'b1 || rsp_hit[m] !== 1'b0 || miss_cnt[m] !== 16'd1 ||
          hit_cnt[m] !== 16'd0) begin
        n_err++;
        $display("[TB] FAIL first_lookup dut%0d: got v=%b hit=%b miss=%0d hits=%0d want 1/0/1/0",
                 m, rsp_valid[m], rsp_hit[m], miss_cnt[m], hit_cnt[m]);
      end
    end
    clear_inputs(); step();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_valid[m] !== 1'b0) begin
        n_err++; $display("[TB] FAIL rsp_one_cycle dut%0d: got %b want 0", m, rsp_valid[m]);
      end
    end
  endtask

  task automatic test_plru_replace();
    logic [DID_W-1:0] probe [5];
    bit               want  [5];
    probe = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd5};
    want  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int d = 1; d <= 4; d++) do_update(DID_W'(d), 4'h0, {24'hD00000, 8'(d)});
    do_lookup(8'd1, 4'h0);
    do_lookup(8'd3, 4'h0);
    do_update(8'd5, 4'h0, {24'hD00000, 8'd5});
    for (int k = 0; k < 5; k++) begin
      do_lookup(probe[k], 4'h0);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (rsp_hit[m] !== want[k] ||
            (want[k] && rsp_data[m] !== {24'hD00000, probe[k]})) begin
          n_err++;
          $display("[TB] FAIL plru_replace dut%0d did=%0d: got hit=%b data=%h want hit=%b",
                   m, probe[k], rsp_hit[m], rsp_data[m], want[k]);
        end
      end
    end
  endtask

  task automatic test_refresh();
    logic [DID_W-1:0] probe [4];
    probe = '{8'd7, 8'd10, 8'd11, 8'd12};
    do_reset();
    do_update(8'd7, 4'h0, 32'h0000_000A);
    do_update(8'd7, 4'h0, 32'h0000_000B);
    for (int k = 1; k < 4; k++) do_update(probe[k], 4'h0, {24'hE00000, probe[k]});
    for (int k = 0; k < 4; k++) begin
      do_lookup(probe[k], 4'h0);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (rsp_hit[m] !== 1'b1 ||
            rsp_data[m] !== ((k == 0) ? 32'h0000_000B : {24'hE00000, probe[k]})) begin
          n_err++;
          $display("[TB] FAIL refresh dut%0d did=%0d: got hit=%b data=%h want hit=1",
                   m, probe[k], rsp_hit[m], rsp_data[m]);
        end
      end
    end
  endtask

  task automatic test_pid_flush();
    logic [DID_W-1:0] kd [3];
    logic [PID_W-1:0] kp [3];
    bit               want [3][3];
    kd   = '{8'd7, 8'd7, 8'd8};
    kp   = '{4'd1, 4'd2, 4'd1};
    want = '{'{1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0}};
    do_reset();
    for (int k = 0; k < 3; k++) do_update(kd[k], kp[k], 32'hC000_0000 | 32'(k));
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0:       do_flush(1'b1, 1'b1, 8'd7, 4'd2);
        1:       do_flush(1'b1, 1'b0, 8'd7, 4'd0);
        default: do_flush(1'b0, 1'b0, 8'd0, 4'd0);
      endcase
      for (int k = 0; k < 3; k++) begin
        do_lookup(kd[k], kp[k]);
        n_vec++;
        if (rsp_hit[1] !== want[ph][k] ||
            (want[ph][k] && rsp_data[1] !== (32'hC000_0000 | 32'(k)))) begin
          n_err++;
          $display("[TB] FAIL pid_flush ph%0d key%0d: got hit=%b data=%h want hit=%b",
                   ph, k, rsp_hit[1], rsp_data[1], want[ph][k]);
        end
        n_vec++;
        if (rsp_hit[0] !== exp_hit[0]) begin
          n_err++;
          $display("[TB] FAIL did_flush ph%0d key%0d: got hit=%b want %b",
                   ph, k, rsp_hit[0], exp_hit[0]);
        end
      end
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    do_update(8'd9, 4'h0, 32'h0000_0A0A);
    clear_inputs();
    lu_valid = 1; lu_did = 8'd9;
    up_valid = 1; up_did = 8'd9; up_data = 32'h0000_0B0B;
    step(); clear_inputs();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_hit[m] !== 1'b1 || rsp_data[m] !== 32'h0000_0A0A) begin
        n_err++;
        $display("[TB] FAIL same_edge_old dut%0d: got hit=%b data=%h want 1/00000a0a",
                 m, rsp_hit[m], rsp_data[m]);
      end
    end
    do_lookup(8'd9, 4'h0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_hit[m] !== 1'b1 || rsp_data[m] !== 32'h0000_0B0B) begin
        n_err++;
        $display("[TB] FAIL same_edge_new dut%0d: got hit=%b data=%h want 1/00000b0b",
                 m, rsp_hit[m], rsp_data[m]);
      end
    end
    clear_inputs();
    flush = 1; flush_dv = 1; flush_did = 8'h55;
    up_valid = 1; up_did = 8'h33; up_data = 32'h3333_3333;
    lu_valid = 1; lu_did = 8'd9;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (ready[m] !== 1'b0) begin
        n_err++; $display("[TB] FAIL flush_ready dut%0d: got %b want 0", m, ready[m]);
      end
    end
    step(); clear_inputs();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_valid[m] !== 1'b0) begin
        n_err++; $display("[TB] FAIL flush_no_accept dut%0d: got %b want 0", m, rsp_valid[m]);
      end
    end
    do_lookup(8'h33, 4'h0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_valid[m] !== 1'b1 || rsp_hit[m] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL update_dropped dut%0d: got v=%b hit=%b want 1/0",
                 m, rsp_valid[m], rsp_hit[m]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    do_update(8'd1, 4'h0, 32'h0000_1111);
    repeat (5) do_lookup(8'd1, 4'h0);
    n_vec++;
    if (hit_cnt[0] !== 16'd3 || hit_cnt[1] !== 16'd5 || miss_cnt[0] !== 16'd0 ||
        miss_cnt[1] !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL saturate: got h0=%0d h1=%0d m0=%0d m1=%0d want 3/5/0/0",
               hit_cnt[0], hit_cnt[1], miss_cnt[0], miss_cnt[1]);
    end
    clear_inputs(); rst = 1; lu_valid = 1; lu_did = 8'd1;
    step(); clear_inputs();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_valid[m] !== 1'b0 || hit_cnt[m] !== 16'd0 || miss_cnt[m] !== 16'd0) begin
        n_err++;
        $display("[TB] FAIL mid_reset dut%0d: got v=%b h=%0d m=%0d want 0/0/0",
                 m, rsp_valid[m], hit_cnt[m], miss_cnt[m]);
      end
    end
    do_lookup(8'd1, 4'h0);
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (rsp_valid[m] !== 1'b1 || rsp_hit[m] !== 1'b0 || miss_cnt[m] !== 16'd1) begin
        n_err++;
        $display("[TB] FAIL reset_invalidates dut%0d: got v=%b hit=%b m=%0d want 1/0/1",
                 m, rsp_valid[m], rsp_hit[m], miss_cnt[m]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      flush_dv  = ($urandom_range(0, 1) == 1);
      flush_pv  = flush_dv && ($urandom_range(0, 1) == 1);
      flush_did = DID_W'($urandom_range(0, 7));
      flush_pid = PID_W'($urandom_range(0, 3));
      up_valid  = ($urandom_range(0, 1) == 1);
      up_did    = DID_W'($urandom_range(0, 7));
      up_pid    = PID_W'($urandom_range(0, 3));
      up_data   = $urandom();
      lu_valid  = ($urandom_range(0, 3) != 0);
      lu_did    = DID_W'($urandom_range(0, 7));
      lu_pid    = PID_W'($urandom_range(0, 3));
      #1;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (ready[m] !== !(flush || rst)) begin
          n_err++;
          $display("[TB] FAIL rnd_ready c%0d dut%0d: got %b want %b", c, m, ready[m], !(flush || rst));
        end
      end
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (rsp_valid[m] !== exp_valid[m]) begin
          n_err++;
          $display("[TB] FAIL rnd_valid c%0d dut%0d: got %b want %b", c, m, rsp_valid[m], exp_valid[m]);
        end
        if (exp_valid[m]) begin
          n_vec++;
          if (rsp_hit[m] !== exp_hit[m] || rsp_data[m] !== exp_data[m]) begin
            n_err++;
            $display("[TB] FAIL rnd_rsp c%0d dut%0d: got hit=%b data=%h want hit=%b data=%h",
                     c, m, rsp_hit[m], rsp_data[m], exp_hit[m], exp_data[m]);
          end
        end
        n_vec++;
        if (hit_cnt[m] !== 16'(m_hits[m]) || miss_cnt[m] !== 16'(m_miss[m])) begin
          n_err++;
          $display("[TB] FAIL rnd_cnt c%0d dut%0d: got h=%0d m=%0d want h=%0d m=%0d",
                   c, m, hit_cnt[m], miss_cnt[m], m_hits[m], m_miss[m]);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_first_lookup();
    test_plru_replace();
    test_refresh();
    test_pid_flush();
    test_same_edge();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
